// File: rtl/uart_tx_fifo_if.sv
// Byte write handshake into the UART transmit FIFO.
interface uart_tx_fifo_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: circular byte FIFO feeding a start/data/stop
// serialiser that chains queued frames back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 106,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  uart_tx_fifo_if.slave               wr,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n, push, pop, cnt_last, has_data;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;

  // Ready looks only at the registered level, so a full FIFO refuses a write
  // even in the cycle it pops.
  assign wr.wr_ready = (level < LW'(FIFO_DEPTH));
  assign push        = wr.wr_valid && wr.wr_ready;
  assign has_data    = (level != '0);
  assign cnt_last    = (cnt == CW'(CLKS_PER_BIT - 1));
  assign busy        = (state != IDLE) || has_data;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        tx_n  = 1'b1;
        if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: if (cnt_last) begin
        cnt_n     = '0;
        bit_idx_n = '0;
        state_n   = DATA;
        tx_n      = shift[0];
      end
      DATA: if (cnt_last) begin
        cnt_n = '0;
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_idx_n = bit_idx + 3'd1;
          shift_n   = {1'b0, shift[7:1]};
          tx_n      = shift[1];
        end
      end
      STOP: if (cnt_last) begin
        cnt_n = '0;
        // Chain straight into the next start bit when more bytes are queued.
        if (has_data) begin
          pop     = 1'b1;
          shift_n = mem[rptr];
          state_n = START;
          tx_n    = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end
endmodule
